// File: rtl/read_prefetch_pkg.sv
// Shared types for the read burst prefetcher: FSM state encoding and FIFO sizing helpers.
package read_prefetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_READ       = 3'd1,
    ST_RELEASE    = 3'd2,
    ST_WAIT_SPACE = 3'd3,
    ST_DRAIN      = 3'd4
  } state_e;

  localparam int unsigned DEFAULT_FIFO_DEPTH = 32'd4;
  localparam int unsigned FIFO_COUNT_WIDTH   = $clog2(DEFAULT_FIFO_DEPTH) + 32'd1;

  function automatic int unsigned fifo_count_width(input int unsigned depth);
    return $clog2(depth) + 32'd1;
  endfunction

endpackage

// File: rtl/read_memory_interface.sv
// Single-word read port shared by a master engine and a memory slave.
interface ReadMemoryInterface #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-1:0] address;
  logic                     readEnabled;
  logic [DATA_WIDTH-1:0]    dataIn;
  logic                     functionComplete;

  modport master (output address, output readEnabled, input dataIn, input functionComplete);
  modport slave  (input address, input readEnabled, output dataIn, output functionComplete);
endinterface

// File: rtl/read_burst_prefetcher_fifo.sv
// First-word fall-through circular buffer holding prefetched read data.
module prefetch_fifo
  import read_prefetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] head_data
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = fifo_count_width(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_push;
  logic                  do_pop;

  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_q == {CNT_W{1'b0}});
  assign head_data = mem_q[rd_ptr_q];

  // Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/read_burst_prefetcher.sv
// Burst read engine: issues sequential single-word reads and streams the results out of a FIFO.
module read_burst_prefetcher
  import read_prefetch_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned LENGTH_WIDTH   = 8,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned ADDRESS_STRIDE = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] startAddress,
  input  logic [LENGTH_WIDTH-1:0]  length,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    dataOut,
  output logic                     dataValid,
  input  logic                     dataReady,
  ReadMemoryInterface.master       memory
);

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [LENGTH_WIDTH-1:0]  remaining_q, remaining_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     read_en_q, read_en_d;
  logic                     capture_s;
  logic                     fifo_full_s;
  logic                     fifo_empty_s;

  assign capture_s        = read_en_q && memory.functionComplete;
  assign busy             = busy_q;
  assign done             = done_q;
  assign dataValid        = !fifo_empty_s;
  assign memory.address     = addr_q;
  assign memory.readEnabled = read_en_q;

  prefetch_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (capture_s),
    .push_data (memory.dataIn),
    .pop       (dataReady),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head_data (dataOut)
  );

  // Outputs are registered from the next state so readEnabled and busy never glitch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && (length != {LENGTH_WIDTH{1'b0}})) begin
          addr_d      = startAddress;
          remaining_d = length;
          state_d     = ST_READ;
        end else if (start) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (capture_s) begin
          addr_d      = addr_q + ADDRESS_WIDTH'(ADDRESS_STRIDE);
          remaining_d = remaining_q - LENGTH_WIDTH'(1);
          state_d     = ST_RELEASE;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_RELEASE: begin
        if (remaining_q == {LENGTH_WIDTH{1'b0}}) begin
          state_d = ST_DRAIN;
        end else if (fifo_full_s) begin
          state_d = ST_WAIT_SPACE;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_WAIT_SPACE: begin
        if (!fifo_full_s) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_WAIT_SPACE;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d    = (state_d != ST_IDLE);
    read_en_d = (state_d == ST_READ);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= {ADDRESS_WIDTH{1'b0}};
      remaining_q <= {LENGTH_WIDTH{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      read_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      read_en_q   <= read_en_d;
    end
  end

endmodule
